// File: rtl/seq_decoder3to8_pkg.sv
// Shared types and helpers for the sequenced 3-to-8 one-cold line decoder.
package seq_decoder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } dec_state_t;

    typedef logic [2:0] code_t;

    localparam logic [7:0] Y_IDLE = 8'hFF;

    function automatic logic [7:0] decode_1cold(input code_t code);
        return ~(8'b1 << code);
    endfunction

endpackage

// File: rtl/seq_decoder3to8_if.sv
// Valid/ready code handshake into the decoder.
interface seq_decoder3to8_if;
    import seq_decoder_pkg::*;

    logic  in_valid;
    code_t in_code;
    logic  in_ready;

    modport master (output in_valid, output in_code, input in_ready);
    modport slave  (input in_valid, input in_code, output in_ready);

endinterface

// File: rtl/seq_decoder3to8_hold_timer.sv
// Loadable down-counter shared by the hold and gap intervals.
module dec_hold_timer #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire,
    output logic             expire_next
);

    logic [CNT_W-1:0] cnt;

    // A load value of N-1 gives an interval of N cycles, the last one with expire high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign expire      = (cnt == '0);
    assign expire_next = (cnt == CNT_W'(1));

endmodule

// File: rtl/seq_decoder3to8.sv
// Sequenced 3-to-8 one-cold decoder: handshake or auto-scan codes, hold the line low, then park high.
module seq_decoder3to8
    import seq_decoder_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1,
    parameter int CNT_W       = $clog2(((HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES) + 1)
) (
    input  logic                clk,
    input  logic                rst,
    seq_decoder3to8_if.slave    in_bus,
    input  logic                scan_en,
    output logic [7:0]          Y,
    output code_t               cur_code,
    output logic                busy,
    output logic                done
);

    localparam bit               HAS_GAP = (GAP_CYCLES > 0);
    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(HAS_GAP ? GAP_CYCLES - 1 : 0);

    dec_state_t       state;
    logic             scan_seq;
    code_t            scan_cnt;

    logic             t_load;
    logic [CNT_W-1:0] t_load_val;
    logic             t_expire;
    logic             t_last;

    logic             accept;
    logic             scan_start;
    logic             drive_end;
    logic             gap_end;
    logic             seq_end;
    logic             chain;
    logic             enter_drive;
    logic             enter_gap;
    logic             done_nxt;

    assign in_bus.in_ready = (state == IDLE) && !scan_en;

    // Only a sequence that scan itself started may chain into the next scan code.
    always_comb begin
        accept      = in_bus.in_valid && in_bus.in_ready;
        scan_start  = (state == IDLE) && scan_en;
        drive_end   = (state == DRIVE) && t_expire;
        gap_end     = (state == GAP) && t_expire;
        seq_end     = HAS_GAP ? gap_end : drive_end;
        chain       = seq_end && scan_seq && scan_en;
        enter_drive = accept || scan_start || chain;
        enter_gap   = drive_end && HAS_GAP;
        t_load      = enter_drive || enter_gap;
        t_load_val  = enter_drive ? HOLD_LD : GAP_LD;

        // done is registered, so it is raised on the edge that enters the final cycle.
        done_nxt = 1'b0;
        if (HAS_GAP) begin
            if (enter_gap && (GAP_CYCLES == 1))
                done_nxt = 1'b1;
            if ((state == GAP) && !t_expire && t_last)
                done_nxt = 1'b1;
        end else begin
            if (enter_drive && (HOLD_CYCLES == 1))
                done_nxt = 1'b1;
            if ((state == DRIVE) && !t_expire && t_last)
                done_nxt = 1'b1;
        end
    end

    dec_hold_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .load        (t_load),
        .load_val    (t_load_val),
        .expire      (t_expire),
        .expire_next (t_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            Y        <= Y_IDLE;
            cur_code <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            scan_cnt <= '0;
            scan_seq <= 1'b0;
        end else begin
            done <= done_nxt;
            case (state)
                IDLE: begin
                    if (scan_start) begin
                        state    <= DRIVE;
                        Y        <= decode_1cold(scan_cnt);
                        cur_code <= scan_cnt;
                        scan_cnt <= scan_cnt + 3'd1;
                        scan_seq <= 1'b1;
                        busy     <= 1'b1;
                    end else if (accept) begin
                        state    <= DRIVE;
                        Y        <= decode_1cold(in_bus.in_code);
                        cur_code <= in_bus.in_code;
                        scan_seq <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                DRIVE: begin
                    if (t_expire) begin
                        if (HAS_GAP) begin
                            state <= GAP;
                            Y     <= Y_IDLE;
                        end else if (chain) begin
                            Y        <= decode_1cold(scan_cnt);
                            cur_code <= scan_cnt;
                            scan_cnt <= scan_cnt + 3'd1;
                        end else begin
                            state <= IDLE;
                            Y     <= Y_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    if (t_expire) begin
                        if (chain) begin
                            state    <= DRIVE;
                            Y        <= decode_1cold(scan_cnt);
                            cur_code <= scan_cnt;
                            scan_cnt <= scan_cnt + 3'd1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    Y     <= Y_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
